// File: rtl/l1_wb_arbiter_pkg.sv
// Shared cache-side definitions for the L1 Wishbone arbiter.
// Holds FSM state encoding, grant ids and burst-length helpers.
package l1_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GNT_IC = 2'd1,
        S_GNT_DC = 2'd2
    } arb_state_t;

    typedef enum logic {
        ID_IC = 1'b0,
        ID_DC = 1'b1
    } gnt_id_t;

    // A zero burst length still moves one beat.
    localparam logic [9:0] BL_ZERO_BEATS = 10'd1;

    function automatic logic [9:0] bl_beats(input logic [9:0] bl);
        return (bl == 10'd0) ? BL_ZERO_BEATS : bl;
    endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin pick between icache and dcache requests.
// Ports: clk/rst; req_ic_i/req_dc_i requests; take_i commits the pick;
// valid_o any request present; gnt_o the master that wins now.
module wb_rr_arb2
    import l1_wb_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_ic_i,
    input  logic    req_dc_i,
    input  logic    take_i,
    output logic    valid_o,
    output gnt_id_t gnt_o
);

    gnt_id_t last_q;

    always_comb begin
        valid_o = req_ic_i | req_dc_i;
        gnt_o   = ID_IC;
        if (req_ic_i && req_dc_i) begin
            // On a tie the master that did not win last time goes first.
            if (last_q == ID_DC) gnt_o = ID_IC;
            else                 gnt_o = ID_DC;
        end else if (req_dc_i) begin
            gnt_o = ID_DC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= ID_DC;
        end else if (take_i && valid_o) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/l1_wb_arbiter.sv
// Arbitrates icache and dcache Wishbone masters onto one memory port.
// Ports: ic_*/dc_* master side (cyc/stb/we/bry/adr/bl, dc write data,
// ack/err/dat responses); wb_* memory side; clk, async active-high rst.
module l1_wb_arbiter
    import l1_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ic_cyc_i,
    input  logic                ic_stb_i,
    input  logic                ic_we_i,
    input  logic                ic_bry_i,
    input  logic [ADDR_LEN-1:0] ic_adr_i,
    input  logic [9:0]          ic_bl_i,
    output logic                ic_ack_o,
    output logic                ic_err_o,
    output logic [DATA_LEN-1:0] ic_dat_o,
    input  logic                dc_cyc_i,
    input  logic                dc_stb_i,
    input  logic                dc_we_i,
    input  logic                dc_bry_i,
    input  logic [ADDR_LEN-1:0] dc_adr_i,
    input  logic [9:0]          dc_bl_i,
    input  logic [DATA_LEN-1:0] dc_dat_i,
    output logic                dc_ack_o,
    output logic                dc_err_o,
    output logic [DATA_LEN-1:0] dc_dat_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic                wb_bry_o,
    output logic [ADDR_LEN-1:0] wb_adr_o,
    output logic [9:0]          wb_bl_o,
    output logic [DATA_LEN-1:0] wb_dat_o,
    input  logic                wb_ack_i,
    input  logic [DATA_LEN-1:0] wb_dat_i
);

    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Watchdog holds silent cycles already spent; the current one is +1.
    localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT - 1);

    arb_state_t     state_q;
    logic [9:0]     beat_q;
    logic [WDW-1:0] wd_q;

    logic    arb_valid;
    gnt_id_t arb_gnt;
    logic    granted;
    logic    m_cyc;
    logic    done;
    logic    abort;
    logic    tmo;

    wb_rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .req_ic_i (ic_cyc_i & ic_stb_i),
        .req_dc_i (dc_cyc_i & dc_stb_i),
        .take_i   (state_q == S_IDLE),
        .valid_o  (arb_valid),
        .gnt_o    (arb_gnt)
    );

    assign ic_dat_o = wb_dat_i;
    assign dc_dat_o = wb_dat_i;

    always_comb begin
        granted = 1'b0;
        m_cyc   = 1'b0;
        unique case (state_q)
            S_GNT_IC: begin
                granted = 1'b1;
                m_cyc   = ic_cyc_i;
            end
            S_GNT_DC: begin
                granted = 1'b1;
                m_cyc   = dc_cyc_i;
            end
            default: ;
        endcase
    end

    // A final ack wins over a same-cycle cyc drop; an ack resets the watchdog.
    assign done  = granted && wb_ack_i && (beat_q == 10'd1);
    assign abort = granted && !m_cyc && !done;
    assign tmo   = granted && m_cyc && !wb_ack_i && (wd_q == WD_LIM);

    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_bry_o = 1'b0;
        wb_adr_o = '0;
        wb_bl_o  = '0;
        wb_dat_o = '0;
        ic_ack_o = 1'b0;
        ic_err_o = 1'b0;
        dc_ack_o = 1'b0;
        dc_err_o = 1'b0;
        unique case (state_q)
            S_GNT_IC: begin
                wb_cyc_o = ic_cyc_i & ~tmo;
                wb_stb_o = ic_stb_i;
                wb_we_o  = ic_we_i;
                wb_bry_o = ic_bry_i;
                wb_adr_o = ic_adr_i;
                wb_bl_o  = ic_bl_i;
                ic_ack_o = wb_ack_i;
                ic_err_o = tmo;
            end
            S_GNT_DC: begin
                wb_cyc_o = dc_cyc_i & ~tmo;
                wb_stb_o = dc_stb_i;
                wb_we_o  = dc_we_i;
                wb_bry_o = dc_bry_i;
                wb_adr_o = dc_adr_i;
                wb_bl_o  = dc_bl_i;
                wb_dat_o = dc_dat_i;
                dc_ack_o = wb_ack_i;
                dc_err_o = tmo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            wd_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        wd_q <= '0;
                        if (arb_gnt == ID_IC) begin
                            state_q <= S_GNT_IC;
                            beat_q  <= bl_beats(ic_bl_i);
                        end else begin
                            state_q <= S_GNT_DC;
                            beat_q  <= bl_beats(dc_bl_i);
                        end
                    end
                end
                S_GNT_IC, S_GNT_DC: begin
                    if (done || abort || tmo) begin
                        state_q <= S_IDLE;
                        beat_q  <= '0;
                        wd_q    <= '0;
                    end else if (wb_ack_i) begin
                        beat_q <= beat_q - 10'd1;
                        wd_q   <= '0;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_wb_arbiter.sv
// Bench for l1_wb_arbiter: directed scenarios, a transaction-level
// ownership model checked every cycle, plus literal expectations.
module tb_l1_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          ic_cyc_i, ic_stb_i, ic_we_i, ic_bry_i;
    logic [AW-1:0] ic_adr_i;
    logic [9:0]    ic_bl_i;
    logic          ic_ack_o, ic_err_o;
    logic [DW-1:0] ic_dat_o;
    logic          dc_cyc_i, dc_stb_i, dc_we_i, dc_bry_i;
    logic [AW-1:0] dc_adr_i;
    logic [9:0]    dc_bl_i;
    logic [DW-1:0] dc_dat_i;
    logic          dc_ack_o, dc_err_o;
    logic [DW-1:0] dc_dat_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_bry_o;
    logic [AW-1:0] wb_adr_o;
    logic [9:0]    wb_bl_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_i;
    logic [DW-1:0] wb_dat_i;

    l1_wb_arbiter #(
        .ADDR_LEN (AW),
        .DATA_LEN (DW),
        .TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ic_cyc_i (ic_cyc_i),
        .ic_stb_i (ic_stb_i),
        .ic_we_i  (ic_we_i),
        .ic_bry_i (ic_bry_i),
        .ic_adr_i (ic_adr_i),
        .ic_bl_i  (ic_bl_i),
        .ic_ack_o (ic_ack_o),
        .ic_err_o (ic_err_o),
        .ic_dat_o (ic_dat_o),
        .dc_cyc_i (dc_cyc_i),
        .dc_stb_i (dc_stb_i),
        .dc_we_i  (dc_we_i),
        .dc_bry_i (dc_bry_i),
        .dc_adr_i (dc_adr_i),
        .dc_bl_i  (dc_bl_i),
        .dc_dat_i (dc_dat_i),
        .dc_ack_o (dc_ack_o),
        .dc_err_o (dc_err_o),
        .dc_dat_o (dc_dat_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_bry_o (wb_bry_o),
        .wb_adr_o (wb_adr_o),
        .wb_bl_o  (wb_bl_o),
        .wb_dat_o (wb_dat_o),
        .wb_ack_i (wb_ack_i),
        .wb_dat_i (wb_dat_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Model: who owns the bus (0 none, 1 IC, 2 DC), who won last,
    // beats left in the burst and silent cycles already waited.
    int m_owner  = 0;
    int m_last   = 2;
    int m_left   = 0;
    int m_waited = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_owner  = 0;
                m_last   = 2;
                m_left   = 0;
                m_waited = 0;
            end else if (m_owner == 0) begin
                int pick;
                int blv;
                bit ri;
                bit rd;
                ri   = ic_cyc_i && ic_stb_i;
                rd   = dc_cyc_i && dc_stb_i;
                pick = 0;
                if (ri && rd) pick = (m_last == 2) ? 1 : 2;
                else if (ri)  pick = 1;
                else if (rd)  pick = 2;
                if (pick != 0) begin
                    m_owner  = pick;
                    m_last   = pick;
                    blv      = (pick == 1) ? int'(ic_bl_i) : int'(dc_bl_i);
                    m_left   = (blv == 0) ? 1 : blv;
                    m_waited = 0;
                end
            end else begin
                bit c;
                c = (m_owner == 1) ? ic_cyc_i : dc_cyc_i;
                if (wb_ack_i && m_left == 1) m_owner = 0;
                else if (!c) m_owner = 0;
                else if (wb_ack_i) begin
                    m_left   = m_left - 1;
                    m_waited = 0;
                end else if (m_waited + 1 == TO) m_owner = 0;
                else m_waited = m_waited + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            begin
                logic          e_cyc, e_stb, e_we, e_bry, tmo;
                logic [AW-1:0] e_adr;
                logic [9:0]    e_bl;
                logic [DW-1:0] e_dat;
                logic [3:0]    e_rsp;
                e_cyc = 0; e_stb = 0; e_we = 0; e_bry = 0;
                e_adr = '0; e_bl = '0; e_dat = '0; e_rsp = '0;
                if (m_owner == 1) begin
                    e_cyc = ic_cyc_i; e_stb = ic_stb_i;
                    e_we  = ic_we_i;  e_bry = ic_bry_i;
                    e_adr = ic_adr_i; e_bl  = ic_bl_i;
                end else if (m_owner == 2) begin
                    e_cyc = dc_cyc_i; e_stb = dc_stb_i;
                    e_we  = dc_we_i;  e_bry = dc_bry_i;
                    e_adr = dc_adr_i; e_bl  = dc_bl_i;
                    e_dat = dc_dat_i;
                end
                tmo = (m_owner != 0) && e_cyc && !wb_ack_i
                      && (m_waited + 1 == TO);
                if (tmo) e_cyc = 1'b0;
                // {ic_ack, ic_err, dc_ack, dc_err}
                if (m_owner == 1) e_rsp = {wb_ack_i, tmo, 2'b00};
                if (m_owner == 2) e_rsp = {2'b00, wb_ack_i, tmo};
                chk("m_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_bry_o, wb_bl_o},
                    {e_cyc, e_stb, e_we, e_bry, e_bl});
                chk("m_adr", wb_adr_o, e_adr);
                chk("m_wdat", wb_dat_o, e_dat);
                chk("m_rsp", {ic_ack_o, ic_err_o, dc_ack_o, dc_err_o}, e_rsp);
                chk("m_rdat", {ic_dat_o, dc_dat_o}, {wb_dat_i, wb_dat_i});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ic_set(input logic c, input logic s, input logic w,
                          input logic b, input logic [AW-1:0] a,
                          input logic [9:0] l);
        ic_cyc_i = c; ic_stb_i = s; ic_we_i = w; ic_bry_i = b;
        ic_adr_i = a; ic_bl_i = l;
    endtask

    task automatic dc_set(input logic c, input logic s, input logic w,
                          input logic b, input logic [AW-1:0] a,
                          input logic [9:0] l, input logic [DW-1:0] d);
        dc_cyc_i = c; dc_stb_i = s; dc_we_i = w; dc_bry_i = b;
        dc_adr_i = a; dc_bl_i = l; dc_dat_i = d;
    endtask

    initial begin
        ic_set(0, 0, 0, 0, '0, '0);
        dc_set(0, 0, 0, 0, '0, '0, '0);
        wb_ack_i = 0;
        wb_dat_i = '0;
        #3;
        chk("rst_cyc", wb_cyc_o, 0);
        wb_dat_i = 32'h1234_5678;
        #1;
        chk("rst_mirror", ic_dat_o, 32'h1234_5678);
        step();
        step();
        rst = 0;
        wb_dat_i = 32'h0BAD_F00D;

        // Tie out of reset: IC first (bl=0 acts as one beat), DC after one gap.
        ic_set(1, 1, 0, 0, 32'h0000_2000, 10'd0);
        dc_set(1, 1, 0, 1, 32'h0000_3000, 10'd1, 32'h0);
        step();
        wb_ack_i = 1; #2;
        chk("tie_first_ic", wb_adr_o, 32'h0000_2000);
        chk("tie_ic_ack", ic_ack_o, 1);
        step();
        wb_ack_i = 0; ic_set(0, 0, 0, 0, '0, '0); #2;
        chk("tie_gap", wb_cyc_o, 0);
        step();
        wb_ack_i = 1; #2;
        chk("tie_then_dc", wb_adr_o, 32'h0000_3000);
        chk("tie_dc_ack", dc_ack_o, 1);
        step();
        wb_ack_i = 0; dc_set(0, 0, 0, 0, '0, '0, '0);

        // IC alone, single beat acked on the third granted cycle.
        step();
        ic_set(1, 1, 0, 0, 32'h0000_1040, 10'd1);
        step(); #2;
        chk("ic_alone_adr", wb_adr_o, 32'h0000_1040);
        step();
        step();
        wb_ack_i = 1; #2;
        chk("ic_alone_ack", ic_ack_o, 1);
        chk("ic_alone_dcack", dc_ack_o, 0);
        step();
        wb_ack_i = 0; ic_set(0, 0, 0, 0, '0, '0); #2;
        chk("ic_alone_idle", wb_cyc_o, 0);

        // DC write burst of 4 with IC waiting throughout.
        step();
        dc_set(1, 1, 1, 0, 32'h0000_4000, 10'd4, 32'hDEAD_BEEF);
        step();
        ic_set(1, 1, 0, 0, 32'h0000_5000, 10'd1);
        wb_ack_i = 1; #2;
        chk("burst_ack1", {dc_ack_o, ic_ack_o}, 2'b10);
        chk("burst_wdat", wb_dat_o, 32'hDEAD_BEEF);
        step();
        step();
        wb_ack_i = 0; #2;
        chk("burst_hold", wb_adr_o, 32'h0000_4000);
        step();
        wb_ack_i = 1;
        step(); #2;
        chk("burst_ack4", dc_ack_o, 1);
        step();
        wb_ack_i = 0; dc_set(0, 0, 0, 0, '0, '0, '0); #2;
        chk("burst_gap", wb_cyc_o, 0);
        step();
        wb_ack_i = 1; #2;
        chk("burst_ic_next", wb_adr_o, 32'h0000_5000);
        step();
        wb_ack_i = 0; ic_set(0, 0, 0, 0, '0, '0);

        // IC granted, memory silent: err on 8th granted cycle.
        step();
        ic_set(1, 1, 0, 0, 32'h0000_6000, 10'd1);
        step();
        dc_set(1, 1, 0, 0, 32'h0000_7000, 10'd1, 32'h0);
        repeat (6) step();
        #2;
        chk("to_quiet7", ic_err_o, 0);
        step(); #2;
        chk("to_err", ic_err_o, 1);
        chk("to_cyc_forced", wb_cyc_o, 0);
        step();
        ic_set(0, 0, 0, 0, '0, '0); #2;
        chk("to_err_once", {ic_err_o, wb_cyc_o}, 2'b00);
        step();
        wb_ack_i = 1; #2;
        chk("to_dc_next", wb_adr_o, 32'h0000_7000);
        step();
        wb_ack_i = 0; dc_set(0, 0, 0, 0, '0, '0, '0);

        // DC aborts after one of four beats; a stray ack follows.
        step();
        dc_set(1, 1, 0, 0, 32'h0000_8000, 10'd4, 32'h0);
        step();
        wb_ack_i = 1; #2;
        chk("abort_ack1", dc_ack_o, 1);
        step();
        wb_ack_i = 0; dc_set(0, 0, 0, 0, '0, '0, '0);
        step();
        wb_ack_i = 1; #2;
        chk("stray_ack", {ic_ack_o, dc_ack_o}, 2'b00);
        step();
        wb_ack_i = 0;
        ic_set(1, 1, 0, 0, 32'h0000_9000, 10'd2);
        step();
        wb_ack_i = 1; #2;
        chk("post_abort_ic", wb_adr_o, 32'h0000_9000);
        step(); #2;
        chk("post_abort_ack2", ic_ack_o, 1);
        step();
        wb_ack_i = 0; ic_set(0, 0, 0, 0, '0, '0); #2;
        chk("post_abort_idle", wb_cyc_o, 0);

        // Reset in the middle of a DC burst, then a tie.
        step();
        dc_set(1, 1, 1, 0, 32'h0000_A000, 10'd4, 32'h0000_0055);
        step();
        wb_ack_i = 1;
        step();
        wb_ack_i = 0; #2;
        chk("pre_rst_cyc", wb_cyc_o, 1);
        rst = 1; #1;
        chk("rst_async_cyc", wb_cyc_o, 0);
        chk("rst_no_err", {ic_err_o, dc_err_o}, 2'b00);
        step();
        step();
        rst = 0;
        ic_set(1, 1, 0, 0, 32'h0000_B000, 10'd1);
        step();
        wb_ack_i = 1; #2;
        chk("rst_tie_ic", wb_adr_o, 32'h0000_B000);
        chk("rst_tie_ack", ic_ack_o, 1);
        step();
        wb_ack_i = 0;
        ic_set(0, 0, 0, 0, '0, '0);
        dc_set(0, 0, 0, 0, '0, '0, '0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
